pingpong_ctrl: RTL and testbench
================================

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter Depth, default 16, meaning words per bank (power of two, >=2).
REQ-002 SHALL have parameter AWidth, default $clog2(Depth), meaning the bank address width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_valid_i, input, 1 bit: the producer offers one word this cycle.
REQ-006 SHALL have port wr_ready_o, output, 1 bit: the controller accepts the offered word this cycle.
REQ-007 SHALL have port wr_en_o, output, 1 bit: write strobe to the bank memories (wr_valid_i & wr_ready_o).
REQ-008 SHALL have port wr_bank_o, output, 1 bit: bank currently being filled (0/1).
REQ-009 SHALL have port wr_addr_o, output, AWidth bits: write address within wr_bank_o.
REQ-010 SHALL have port rd_ready_i, input, 1 bit: the consumer requests one word this cycle.
REQ-011 SHALL have port rd_en_o, output, 1 bit: read strobe to the bank memories.
REQ-012 SHALL have port rd_bank_o, output, 1 bit: bank currently being drained.
REQ-013 SHALL have port rd_addr_o, output, AWidth bits: read address within rd_bank_o.
REQ-014 SHALL have port sel_o, output, 1 bit: downstream 2:1 data-mux select, equal to the bank of the read issued last cycle.
REQ-015 SHALL have port rd_valid_o, output, 1 bit: the mux output holds valid read data this cycle.

Function
REQ-016 SHALL keep a per-bank state in {EMPTY, FULL}, plus one write pointer and one read pointer, each holding a bank bit and an AWidth-bit address.
REQ-017 SHALL assert wr_ready_o only when the state of bank wr_bank_o is EMPTY.
REQ-018 SHALL, on each accepted write, increment wr_addr_o modulo Depth.
REQ-019 SHALL, on an accepted write at address Depth-1, set that bank FULL, wrap wr_addr_o to 0 and toggle wr_bank_o, all in the same edge.
REQ-020 SHALL assert rd_en_o = rd_ready_i & (state of bank rd_bank_o == FULL).
REQ-021 SHALL, on each rd_en_o, increment rd_addr_o modulo Depth.
REQ-022 SHALL, on rd_en_o at address Depth-1, set that bank EMPTY, wrap rd_addr_o to 0 and toggle rd_bank_o.
REQ-023 SHALL make rd_valid_o equal to rd_en_o delayed one cycle, matching the 1-cycle synchronous bank read latency.
REQ-024 SHALL make sel_o equal to rd_bank_o registered on rd_en_o, and hold it otherwise, so sel_o is stable while rd_valid_o=1.
REQ-025 SHALL, when a FULL-set from the write side and an EMPTY-set from the read side target different banks in the same cycle, apply both updates.
REQ-026 SHALL never see both updates target the same bank in one cycle: the write side needs that bank EMPTY and the read side needs it FULL.
REQ-027 SHALL deassert wr_ready_o when both banks are FULL; the producer stalls with no word lost.
REQ-028 SHALL keep rd_en_o at 0 when both banks are EMPTY, regardless of rd_ready_i.
REQ-029 SHALL give throughput of one write and one read per cycle concurrently when the banks are in opposite states.

Reset
REQ-030 SHALL, on rst_i=1 at a clock edge, set both banks EMPTY, wr_bank_o=0, wr_addr_o=0, rd_bank_o=0, rd_addr_o=0, sel_o=0 and rd_valid_o=0.
REQ-031 SHALL give the following combinational outputs after reset: wr_ready_o=1, wr_en_o=wr_valid_i, rd_en_o=0.
REQ-032 SHALL, on reset asserted mid-operation, discard all partial-bank contents and state with no residual rd_valid_o pulse on the following cycle.

Structure
REQ-033 SHALL take the bank-state enum (EMPTY/FULL) and the default Depth constant from the shared accelerator package.
REQ-034 SHALL build both pointers from one sub-module, pp_ptr, instantiated twice: an AWidth-bit address plus bank bit, with an increment enable and a wrap output.
REQ-035 SHALL drive the existing 2:1 data mux directly from sel_o, with no further logic between them.

Verification
REQ-036 SHALL cover this scenario: Depth=4, write 4 words continuously after reset -> wr_addr_o 0,1,2,3; bank0 FULL; wr_bank_o=1 on the 5th cycle.
REQ-037 SHALL cover this scenario: bank0 FULL, rd_ready_i=1 for 4 cycles -> rd_addr_o 0..3; rd_valid_o high on cycles 2..5; sel_o=0; bank0 EMPTY afterwards.
REQ-038 SHALL cover this scenario: with 8 words written and no reads -> wr_ready_o=0 while wr_valid_i=1; after one full bank is drained, wr_ready_o=1 again.
REQ-039 SHALL cover this scenario: concurrent fill of bank1 and drain of bank0, both finishing at address 3 in the same cycle -> bank1 FULL, bank0 EMPTY, both pointers toggle.
REQ-040 SHALL cover this scenario: rd_ready_i=1 with both banks EMPTY -> rd_en_o=0 and rd_valid_o=0.
REQ-041 SHALL cover this scenario: rst_i pulsed after 2 writes into bank1 -> next cycle all reset values hold and wr_addr_o=0 on bank0.

Source files
------------

// File: rtl/pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong bank controller.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Holds the bank-state encoding and the default bank depth.
package pingpong_ctrl_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

endpackage

// File: rtl/pingpong_ctrl_if.sv
// Handshake and bank-strobe bundle between producer/consumer and the ping-pong controller.
// Latency: n/a (wires only). Backpressure: wr_ready_o stalls the producer.
// The master modport is the environment side; slave is the controller side.
interface pingpong_ctrl_if
  import pingpong_ctrl_pkg::*;
#(
  parameter int AWidth = $clog2(DEFAULT_DEPTH)
);

  logic              wr_valid_i;
  logic              wr_ready_o;
  logic              wr_en_o;
  logic              wr_bank_o;
  logic [AWidth-1:0] wr_addr_o;
  logic              rd_ready_i;
  logic              rd_en_o;
  logic              rd_bank_o;
  logic [AWidth-1:0] rd_addr_o;
  logic              sel_o;
  logic              rd_valid_o;

  modport master (
    output wr_valid_i,
    output rd_ready_i,
    input  wr_ready_o,
    input  wr_en_o,
    input  wr_bank_o,
    input  wr_addr_o,
    input  rd_en_o,
    input  rd_bank_o,
    input  rd_addr_o,
    input  sel_o,
    input  rd_valid_o
  );

  modport slave (
    input  wr_valid_i,
    input  rd_ready_i,
    output wr_ready_o,
    output wr_en_o,
    output wr_bank_o,
    output wr_addr_o,
    output rd_en_o,
    output rd_bank_o,
    output rd_addr_o,
    output sel_o,
    output rd_valid_o
  );

endinterface

// File: rtl/pingpong_ctrl_ptr.sv
// Bank pointer: address within a bank plus the bank bit, advanced by inc.
// Latency: address/bank update on the edge after inc; wrap is combinational.
// Backpressure: none, the caller gates inc.
module pp_ptr #(
  parameter int Depth  = 16,
  parameter int AWidth = $clog2(Depth)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic              bank,
  output logic [AWidth-1:0] addr,
  output logic              wrap
);

  localparam logic [AWidth-1:0] LastAddr = AWidth'(Depth - 1);

  assign wrap = inc && (addr == LastAddr);

  // Depth is a power of two, so the natural roll-over of addr is the modulo.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      bank <= 1'b0;
    end else if (inc) begin
      addr <= addr + 1'b1;
      if (wrap) begin
        bank <= ~bank;
      end
    end
  end

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong double-buffer controller: producer fills one bank while the consumer drains the other.
// Latency: rd_valid_o/sel_o one cycle after rd_en_o; strobes are combinational from the handshake.
// Backpressure: wr_ready_o drops while the target bank is FULL; reads only issue from a FULL bank.
module pingpong_ctrl
  import pingpong_ctrl_pkg::*;
#(
  parameter int Depth  = DEFAULT_DEPTH,
  parameter int AWidth = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pingpong_ctrl_if.slave   bus
);

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];

  logic              wr_bank;
  logic [AWidth-1:0] wr_addr;
  logic              wr_wrap;
  logic              wr_ready;
  logic              wr_en;

  logic              rd_bank;
  logic [AWidth-1:0] rd_addr;
  logic              rd_wrap;
  logic              rd_en;

  logic              sel_q;
  logic              rd_valid_q;

  assign wr_ready = (state_q[wr_bank] == EMPTY);
  assign wr_en    = bus.wr_valid_i && wr_ready;
  assign rd_en    = bus.rd_ready_i && (state_q[rd_bank] == FULL);

  pp_ptr #(
    .Depth  (Depth),
    .AWidth (AWidth)
  ) u_wr_ptr (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (wr_en),
    .bank (wr_bank),
    .addr (wr_addr),
    .wrap (wr_wrap)
  );

  pp_ptr #(
    .Depth  (Depth),
    .AWidth (AWidth)
  ) u_rd_ptr (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (rd_en),
    .bank (rd_bank),
    .addr (rd_addr),
    .wrap (rd_wrap)
  );

  // A wrapping write targets an EMPTY bank and a wrapping read a FULL one,
  // so the two updates can never land on the same bank in one cycle.
  always_comb begin
    state_d = state_q;
    if (wr_wrap) begin
      state_d[wr_bank] = FULL;
    end
    if (rd_wrap) begin
      state_d[rd_bank] = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // sel_o follows the bank of the last issued read and holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        sel_q <= rd_bank;
      end
    end
  end

  assign bus.wr_ready_o = wr_ready;
  assign bus.wr_en_o    = wr_en;
  assign bus.wr_bank_o  = wr_bank;
  assign bus.wr_addr_o  = wr_addr;
  assign bus.rd_en_o    = rd_en;
  assign bus.rd_bank_o  = rd_bank;
  assign bus.rd_addr_o  = rd_addr;
  assign bus.sel_o      = sel_q;
  assign bus.rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Bench for pingpong_ctrl with Depth=4: directed scenarios then random traffic,
// bank memories modelled here, data ordering checked through a scoreboard queue.
module tb_pingpong_ctrl;

  localparam int D  = 4;
  localparam int AW = 2;

  typedef struct {
    logic [15:0] data;
    logic        bank;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_data;
  logic [15:0] mem [2][D];
  logic [15:0] rd_word [2];

  int   tests = 0;
  int   fails = 0;

  // Reference model: words are numbered 0..2D-1 around the two banks.
  int   wr_idx;
  int   rd_idx;
  bit   full [2];
  bit   exp_rv;
  bit   exp_sel;
  exp_t exp_q [$];

  pingpong_ctrl_if #(.AWidth(AW)) bus ();

  pingpong_ctrl #(
    .Depth  (D),
    .AWidth (AW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bank memories with one-cycle synchronous read, muxed by sel_o.
  always @(posedge clk) begin
    if (bus.wr_en_o === 1'b1) mem[bus.wr_bank_o][bus.wr_addr_o] <= wr_data;
    if (bus.rd_en_o === 1'b1) rd_word[bus.rd_bank_o] <= mem[bus.rd_bank_o][bus.rd_addr_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_idx  = 0;
    rd_idx  = 0;
    full[0] = 1'b0;
    full[1] = 1'b0;
    exp_rv  = 1'b0;
    exp_sel = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at negedge, compare just after, then advance the model.
  task automatic cycle(input bit wv, input bit rr, input bit r, input bit chk);
    int wb, wa, rb, ra;
    bit e_wr_rdy, e_wr_en, e_rd_en;
    @(negedge clk);
    bus.wr_valid_i = wv;
    bus.rd_ready_i = rr;
    rst            = r;
    wr_data        = 16'($urandom);
    #1;
    wb       = wr_idx / D;
    wa       = wr_idx % D;
    rb       = rd_idx / D;
    ra       = rd_idx % D;
    e_wr_rdy = !full[wb];
    e_wr_en  = wv && e_wr_rdy;
    e_rd_en  = rr && full[rb];
    if (chk) begin
      check("wr_ready", 32'(bus.wr_ready_o), 32'(e_wr_rdy));
      check("wr_en",    32'(bus.wr_en_o),    32'(e_wr_en));
      check("wr_bank",  32'(bus.wr_bank_o),  32'(wb));
      check("wr_addr",  32'(bus.wr_addr_o),  32'(wa));
      check("rd_en",    32'(bus.rd_en_o),    32'(e_rd_en));
      check("rd_bank",  32'(bus.rd_bank_o),  32'(rb));
      check("rd_addr",  32'(bus.rd_addr_o),  32'(ra));
      check("rd_valid", 32'(bus.rd_valid_o), 32'(exp_rv));
      check("sel",      32'(bus.sel_o),      32'(exp_sel));
    end
    if (r) begin
      model_reset();
    end else begin
      if (e_wr_en) begin
        exp_q.push_back('{data: wr_data, bank: wb[0]});
        if (wa == D - 1) full[wb] = 1'b1;
        wr_idx = (wr_idx + 1) % (2 * D);
      end
      if (e_rd_en) begin
        if (ra == D - 1) full[rb] = 1'b0;
        rd_idx  = (rd_idx + 1) % (2 * D);
        exp_sel = rb[0];
      end
      exp_rv = e_rd_en;
    end
  endtask

  // Scoreboard monitor: every valid read beat must match the oldest written word.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rd_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_data: valid read beat %0h with no word outstanding (t=%0t)",
                 rd_word[bus.sel_o], $time);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 32'(rd_word[bus.sel_o]), 32'(e.data));
        check("rd_sel",  32'(bus.sel_o),          32'(e.bank));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.wr_valid_i = 1'b0;
    bus.rd_ready_i = 1'b0;
    wr_data        = '0;
    model_reset();

    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 1);                         // reset values, wr_en follows wr_valid

    repeat (4) cycle(1, 0, 0, 1);              // fill bank0, addr 0..3
    cycle(0, 0, 0, 1);                         // wr_bank now 1

    repeat (4) cycle(0, 1, 0, 1);              // drain bank0
    repeat (2) cycle(0, 0, 0, 1);

    repeat (10) cycle(1, 0, 0, 1);             // 8 words, then stalled producer
    repeat (4) cycle(0, 1, 0, 1);              // drain bank1, bank0 still FULL

    repeat (4) cycle(1, 1, 0, 1);              // fill bank1 while draining bank0
    cycle(0, 0, 0, 1);

    repeat (4) cycle(0, 1, 0, 1);              // drain bank1
    repeat (3) cycle(0, 1, 0, 1);              // both EMPTY: no reads

    repeat (6) cycle(1, 0, 0, 1);              // bank0 full, 2 words into bank1
    cycle(0, 1, 1, 1);                         // reset while a read is requested
    cycle(1, 1, 0, 1);                         // reset state, no residual rd_valid
    cycle(0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 149) == 0, 1);
    end

    for (int i = 0; i < 4 * D; i++) cycle(0, 1, 0, 1);
    repeat (2) cycle(0, 0, 0, 1);
    check("leftover_words", 32'(exp_q.size()), 32'(wr_idx % D));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
